// File: rtl/align_pkg.sv
// Shared definitions for the alignment traceback path.
//   SCORE_W / IDX_W : width of score values and matrix indices.
//   op_t            : op codes streamed out by the traceback (00 is never emitted).
//   tb_state_t      : traceback FSM states, also exported on the debug state output.
package align_pkg;

    localparam int SCORE_W = 32;
    localparam int IDX_W   = 32;

    typedef enum logic [1:0] {
        OP_DIAG = 2'b01,
        OP_UP   = 2'b10,
        OP_LEFT = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RD_CUR,
        RD_DIAG,
        RD_UP,
        DECIDE,
        EMIT,
        DONE
    } tb_state_t;

endpackage

// File: rtl/tb_decide.sv
// Combinational move selection for one interior traceback step.
//   i_cur  : H[i][j]
//   i_diag : H[i-1][j-1]
//   i_up   : H[i-1][j]
//   i_a    : symbol a[i]
//   i_b    : symbol b[j]
//   o_op   : chosen move (DIAG, then UP, then LEFT by priority)
// Scores wrap modulo 2^SCORE_W and are compared for exact equality.
module tb_decide
    import align_pkg::*;
#(
    parameter int MATCH    = 1,
    parameter int MISMATCH = 0,
    parameter int GAP      = 0
) (
    input  logic [SCORE_W-1:0] i_cur,
    input  logic [SCORE_W-1:0] i_diag,
    input  logic [SCORE_W-1:0] i_up,
    input  logic [SCORE_W-1:0] i_a,
    input  logic [SCORE_W-1:0] i_b,
    output logic [1:0]         o_op
);

    logic [SCORE_W-1:0] w_diag_score;
    logic [SCORE_W-1:0] w_up_score;

    always_comb begin
        w_diag_score = i_diag + ((i_a == i_b) ? SCORE_W'(MATCH) : SCORE_W'(MISMATCH));
        w_up_score   = i_up + SCORE_W'(GAP);
        if (w_diag_score == i_cur) begin
            o_op = OP_DIAG;
        end else if (w_up_score == i_cur) begin
            o_op = OP_UP;
        end else begin
            // LEFT is taken without a confirming read.
            o_op = OP_LEFT;
        end
    end

endmodule

// File: rtl/traceback_unit.sv
// Walks a filled score matrix from (N,M) back to (0,0) and streams the
// alignment as ops.
//   clk, reset          : clock, asynchronous active-low reset
//   start               : begin a walk (accepted only in IDLE or DONE)
//   rd_en, rd_i, rd_j   : read request to the matrix store (1-cycle latency)
//   rd_score, rd_a, rd_b: read data, valid the cycle after rd_en
//   op_valid, op_ready  : op stream handshake
//   op_code, op_i, op_j : move and the cell it leaves
//   finish, error       : walk complete / matrix inconsistency (valid with finish)
//   length              : number of ops emitted in this walk
//   dbg_state           : current FSM state
//
// Handshake: an op transfers on a rising edge where op_valid && op_ready.
// Once op_valid rises, op_code/op_i/op_j stay stable and op_valid stays high
// until that transfer happens.
//
// Interior step: LOAD, RD_CUR, RD_DIAG, RD_UP, DECIDE, EMIT. Reads issued in
// RD_CUR/RD_DIAG/RD_UP return in RD_DIAG/RD_UP/DECIDE respectively, so each
// state captures the data of the previous request. Boundary step (row or
// column 0): LOAD, EMIT.
module traceback_unit
    import align_pkg::*;
#(
    parameter int N        = 5,
    parameter int M        = 5,
    parameter int MATCH    = 1,
    parameter int MISMATCH = 0,
    parameter int GAP      = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               rd_en,
    output logic [IDX_W-1:0]   rd_i,
    output logic [IDX_W-1:0]   rd_j,
    input  logic [SCORE_W-1:0] rd_score,
    input  logic [SCORE_W-1:0] rd_a,
    input  logic [SCORE_W-1:0] rd_b,
    output logic               op_valid,
    input  logic               op_ready,
    output logic [1:0]         op_code,
    output logic [IDX_W-1:0]   op_i,
    output logic [IDX_W-1:0]   op_j,
    output logic               finish,
    output logic               error,
    output logic [31:0]        length,
    output logic [2:0]         dbg_state
);

    tb_state_t          r_state;
    logic [IDX_W-1:0]   r_i;
    logic [IDX_W-1:0]   r_j;
    logic [SCORE_W-1:0] r_cur;
    logic [SCORE_W-1:0] r_diag;
    logic [SCORE_W-1:0] r_a;
    logic [SCORE_W-1:0] r_b;
    // Set when a LEFT move drops onto column 0 from an interior cell; the
    // remaining UP chain always lands on (0,0), so it is reported at DONE.
    logic               r_left_edge;
    logic [1:0]         w_op;

    assign dbg_state = r_state;

    // Up score is consumed straight from the read port in DECIDE.
    tb_decide #(
        .MATCH    (MATCH),
        .MISMATCH (MISMATCH),
        .GAP      (GAP)
    ) u_decide (
        .i_cur  (r_cur),
        .i_diag (r_diag),
        .i_up   (rd_score),
        .i_a    (r_a),
        .i_b    (r_b),
        .o_op   (w_op)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_i         <= '0;
            r_j         <= '0;
            r_cur       <= '0;
            r_diag      <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_left_edge <= 1'b0;
            rd_en       <= 1'b0;
            rd_i        <= '0;
            rd_j        <= '0;
            op_valid    <= 1'b0;
            op_code     <= 2'b00;
            op_i        <= '0;
            op_j        <= '0;
            finish      <= 1'b0;
            error       <= 1'b0;
            length      <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_i         <= IDX_W'(N);
                        r_j         <= IDX_W'(M);
                        length      <= '0;
                        error       <= 1'b0;
                        finish      <= 1'b0;
                        r_left_edge <= 1'b0;
                        r_state     <= LOAD;
                    end
                end
                LOAD: begin
                    if (r_i == '0 && r_j == '0) begin
                        finish  <= 1'b1;
                        error   <= r_left_edge;
                        r_state <= DONE;
                    end else if (r_i == '0) begin
                        op_code  <= OP_LEFT;
                        op_i     <= r_i;
                        op_j     <= r_j;
                        op_valid <= 1'b1;
                        r_state  <= EMIT;
                    end else if (r_j == '0) begin
                        op_code  <= OP_UP;
                        op_i     <= r_i;
                        op_j     <= r_j;
                        op_valid <= 1'b1;
                        r_state  <= EMIT;
                    end else begin
                        rd_en   <= 1'b1;
                        rd_i    <= r_i;
                        rd_j    <= r_j;
                        r_state <= RD_CUR;
                    end
                end
                RD_CUR: begin
                    rd_i    <= r_i - 1'b1;
                    rd_j    <= r_j - 1'b1;
                    r_state <= RD_DIAG;
                end
                RD_DIAG: begin
                    r_cur   <= rd_score;
                    r_a     <= rd_a;
                    r_b     <= rd_b;
                    rd_i    <= r_i - 1'b1;
                    rd_j    <= r_j;
                    r_state <= RD_UP;
                end
                RD_UP: begin
                    r_diag  <= rd_score;
                    rd_en   <= 1'b0;
                    r_state <= DECIDE;
                end
                DECIDE: begin
                    op_code  <= w_op;
                    op_i     <= r_i;
                    op_j     <= r_j;
                    op_valid <= 1'b1;
                    if (w_op == OP_LEFT && r_j == IDX_W'(1)) begin
                        r_left_edge <= 1'b1;
                    end
                    r_state <= EMIT;
                end
                EMIT: begin
                    if (op_ready) begin
                        op_valid <= 1'b0;
                        length   <= length + 32'd1;
                        case (op_code)
                            OP_DIAG: begin
                                r_i <= r_i - 1'b1;
                                r_j <= r_j - 1'b1;
                            end
                            OP_UP:   r_i <= r_i - 1'b1;
                            default: r_j <= r_j - 1'b1;
                        endcase
                        r_state <= LOAD;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_traceback_unit.sv
module tb_traceback_unit;
    import align_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start;
    logic op_ready;
    int   sel;
    int   total = 0;
    int   bad   = 0;

    // expected op: {code[1:0], i[7:0], j[7:0]}
    logic [17:0] exp_q[$];

    // ---------------- matrices ----------------
    logic [31:0] h5 [0:5][0:5];
    logic [31:0] a5 [0:5];
    logic [31:0] b5 [0:5];
    logic [31:0] h21 [0:2][0:1];
    logic [31:0] a21 [0:2];
    logic [31:0] b21 [0:1];
    logic [31:0] zero32;
    assign zero32 = 32'd0;

    // ---------------- DUT signals ----------------
    logic        u5_rd_en, u20_rd_en, u21_rd_en;
    logic [31:0] u5_rd_i, u5_rd_j, u20_rd_i, u20_rd_j, u21_rd_i, u21_rd_j;
    logic [31:0] u5_score, u5_a, u5_b, u21_score, u21_a, u21_b;
    logic        u5_op_valid, u20_op_valid, u21_op_valid;
    logic [1:0]  u5_op_code, u20_op_code, u21_op_code;
    logic [31:0] u5_op_i, u5_op_j, u20_op_i, u20_op_j, u21_op_i, u21_op_j;
    logic        u5_finish, u20_finish, u21_finish;
    logic        u5_error, u20_error, u21_error;
    logic [31:0] u5_length, u20_length, u21_length;
    logic [2:0]  u5_state, u20_state, u21_state;
    logic        st5, st20, st21;

    assign st5  = start && (sel == 0);
    assign st20 = start && (sel == 1);
    assign st21 = start && (sel == 2);

    traceback_unit #(.N(5), .M(5), .MATCH(1), .MISMATCH(0), .GAP(0)) u5 (
        .clk(clk), .reset(reset), .start(st5),
        .rd_en(u5_rd_en), .rd_i(u5_rd_i), .rd_j(u5_rd_j),
        .rd_score(u5_score), .rd_a(u5_a), .rd_b(u5_b),
        .op_valid(u5_op_valid), .op_ready(op_ready), .op_code(u5_op_code),
        .op_i(u5_op_i), .op_j(u5_op_j), .finish(u5_finish), .error(u5_error),
        .length(u5_length), .dbg_state(u5_state)
    );

    traceback_unit #(.N(2), .M(0), .MATCH(1), .MISMATCH(0), .GAP(0)) u20 (
        .clk(clk), .reset(reset), .start(st20),
        .rd_en(u20_rd_en), .rd_i(u20_rd_i), .rd_j(u20_rd_j),
        .rd_score(zero32), .rd_a(zero32), .rd_b(zero32),
        .op_valid(u20_op_valid), .op_ready(op_ready), .op_code(u20_op_code),
        .op_i(u20_op_i), .op_j(u20_op_j), .finish(u20_finish), .error(u20_error),
        .length(u20_length), .dbg_state(u20_state)
    );

    traceback_unit #(.N(2), .M(1), .MATCH(1), .MISMATCH(0), .GAP(0)) u21 (
        .clk(clk), .reset(reset), .start(st21),
        .rd_en(u21_rd_en), .rd_i(u21_rd_i), .rd_j(u21_rd_j),
        .rd_score(u21_score), .rd_a(u21_a), .rd_b(u21_b),
        .op_valid(u21_op_valid), .op_ready(op_ready), .op_code(u21_op_code),
        .op_i(u21_op_i), .op_j(u21_op_j), .finish(u21_finish), .error(u21_error),
        .length(u21_length), .dbg_state(u21_state)
    );

    // 1-cycle-latency matrix store models
    always @(posedge clk) begin
        if (u5_rd_en) begin
            u5_score <= h5[u5_rd_i[2:0]][u5_rd_j[2:0]];
            u5_a     <= a5[u5_rd_i[2:0]];
            u5_b     <= b5[u5_rd_j[2:0]];
        end
        if (u21_rd_en) begin
            u21_score <= h21[u21_rd_i[1:0]][u21_rd_j[0]];
            u21_a     <= a21[u21_rd_i[1:0]];
            u21_b     <= b21[u21_rd_j[0]];
        end
    end

    // selected instance view
    logic        m_op_valid, m_finish, m_error;
    logic [1:0]  m_op_code;
    logic [31:0] m_op_i, m_op_j, m_length;
    logic [2:0]  m_state;

    always_comb begin
        m_op_valid = u5_op_valid; m_op_code = u5_op_code; m_op_i = u5_op_i; m_op_j = u5_op_j;
        m_finish = u5_finish; m_error = u5_error; m_length = u5_length; m_state = u5_state;
        case (sel)
            1: begin
                m_op_valid = u20_op_valid; m_op_code = u20_op_code; m_op_i = u20_op_i; m_op_j = u20_op_j;
                m_finish = u20_finish; m_error = u20_error; m_length = u20_length; m_state = u20_state;
            end
            2: begin
                m_op_valid = u21_op_valid; m_op_code = u21_op_code; m_op_i = u21_op_i; m_op_j = u21_op_j;
                m_finish = u21_finish; m_error = u21_error; m_length = u21_length; m_state = u21_state;
            end
            default: ;
        endcase
    end

    // ---------------- driver / checker tasks ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_op(input logic [1:0] c, input int i, input int j);
        exp_q.push_back({c, i[7:0], j[7:0]});
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Edges after the start-sampling edge until op_valid is seen.
    task automatic first_op_latency(input string tag, input int exp_lat);
        int k;
        k = 0;
        pulse_start();
        while (!m_op_valid && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_lat"}, k, exp_lat);
    endtask

    task automatic wait_op(input string tag);
        logic [17:0] e;
        int k;
        e = exp_q.pop_front();
        k = 0;
        @(negedge clk);
        while (!m_op_valid && k < 60) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_valid"}, m_op_valid, 1);
        check({tag, "_code"}, m_op_code, e[17:16]);
        check({tag, "_i"}, m_op_i, e[15:8]);
        check({tag, "_j"}, m_op_j, e[7:0]);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) wait_op(tag);
    endtask

    task automatic wait_done(input string tag, input int len, input logic err);
        int k;
        k = 0;
        @(negedge clk);
        while (!m_finish && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_finish"}, m_finish, 1);
        check({tag, "_length"}, m_length, len);
        check({tag, "_error"}, m_error, err);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ctl"}, {u5_rd_en, u5_op_valid, u5_finish, u5_error, u5_op_code}, 0);
        check({tag, "_rd_ij"}, u5_rd_i | u5_rd_j, 0);
        check({tag, "_op_ij"}, u5_op_i | u5_op_j, 0);
        check({tag, "_length"}, u5_length, 0);
        check({tag, "_state"}, u5_state, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int k;
        int cnt;
        logic [2:0] prev;

        for (int i = 0; i <= 5; i++) begin
            a5[i] = i;
            b5[i] = i;
            for (int j = 0; j <= 5; j++) h5[i][j] = (i < j) ? i : j;
        end
        // A = 1,2 ; B = 2 ; MATCH=1, MISMATCH=0, GAP=0
        a21[0] = 0; a21[1] = 1; a21[2] = 2;
        b21[0] = 0; b21[1] = 2;
        h21[0][0] = 0; h21[0][1] = 0;
        h21[1][0] = 0; h21[1][1] = 0;
        h21[2][0] = 0; h21[2][1] = 1;

        reset = 1'b0;
        start = 1'b0;
        op_ready = 1'b1;
        sel = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b1;

        // diagonal walk on H = min(i,j)
        sel = 0;
        for (int d = 5; d >= 1; d--) push_op(OP_DIAG, d, d);
        first_op_latency("t1", 5);
        drain("t1");
        wait_done("t1", 5, 1'b0);

        // restart from DONE, consumer stalls 3 cycles on the 2nd op
        for (int d = 5; d >= 1; d--) push_op(OP_DIAG, d, d);
        first_op_latency("t2", 5);
        wait_op("t2");
        op_ready = 1'b0;
        k = 0;
        @(negedge clk);
        while (!m_op_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        for (int c = 0; c < 3; c++) begin
            check("t2_hold_valid", m_op_valid, 1);
            check("t2_hold_code", m_op_code, 2'b01);
            check("t2_hold_i", m_op_i, 4);
            check("t2_hold_j", m_op_j, 4);
            if (c < 2) @(negedge clk);
        end
        void'(exp_q.pop_front());
        op_ready = 1'b1;
        @(posedge clk);
        #1;
        drain("t2");
        wait_done("t2", 5, 1'b0);

        // N=2, M=0: boundary only
        sel = 1;
        push_op(OP_UP, 2, 0);
        push_op(OP_UP, 1, 0);
        first_op_latency("t3", 1);
        drain("t3");
        wait_done("t3", 2, 1'b0);

        // A=1,2 B=2
        sel = 2;
        push_op(OP_DIAG, 2, 1);
        push_op(OP_UP, 1, 0);
        first_op_latency("t4", 5);
        drain("t4");
        wait_done("t4", 2, 1'b0);

        // inconsistent cell forces LEFT onto column 0 -> error
        h21[2][1] = 5;
        push_op(OP_LEFT, 2, 1);
        push_op(OP_UP, 2, 0);
        push_op(OP_UP, 1, 0);
        first_op_latency("t4e", 5);
        drain("t4e");
        wait_done("t4e", 3, 1'b1);

        // error clears on the next accepted start
        h21[2][1] = 1;
        push_op(OP_DIAG, 2, 1);
        push_op(OP_UP, 1, 0);
        first_op_latency("t4c", 5);
        drain("t4c");
        wait_done("t4c", 2, 1'b0);

        // reset in the 3rd RD_DIAG
        sel = 0;
        pulse_start();
        cnt = 0;
        k = 0;
        prev = m_state;
        while (cnt < 3 && k < 200) begin
            @(negedge clk);
            k++;
            if (m_state == RD_DIAG && prev != RD_DIAG) cnt++;
            prev = m_state;
        end
        check("t5_reached", cnt, 3);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_reset_vals("t5_rst");
        @(negedge clk);
        reset = 1'b1;
        for (int d = 5; d >= 1; d--) push_op(OP_DIAG, d, d);
        first_op_latency("t5", 5);
        drain("t5");
        wait_done("t5", 5, 1'b0);

        // start during EMIT is ignored
        op_ready = 1'b0;
        for (int d = 5; d >= 1; d--) push_op(OP_DIAG, d, d);
        first_op_latency("t6", 5);
        pulse_start();
        @(negedge clk);
        check("t6_state", m_state, EMIT);
        check("t6_valid", m_op_valid, 1);
        check("t6_code", m_op_code, 2'b01);
        check("t6_i", m_op_i, 5);
        check("t6_j", m_op_j, 5);
        @(posedge clk);
        #1 op_ready = 1'b1;
        drain("t6");
        wait_done("t6", 5, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
